// File: rtl/camera_msg_gen.sv
// ---------------------------------------------------------------------------
// camera_msg_gen
//
// On-chip camera emulator. Produces frame-timed pixel messages for the
// PC->FPGA pixel path and writes them into the bus-side message FIFO under
// almost-full flow control.
//
// Message word layout:
//   bit0 = 0 (pixel message), bit1 = 0, bit4 = LVAL, bit5 = FVAL,
//   bits[19:8] = DN, all other bits 0.
//
// Ports:
//   bus_clk      in   sole clock
//   reset_n      in   synchronous active-low reset
//   start        in   one-cycle run request, ignored while busy
//   stop         in   level, sampled at the last pixel word of a frame
//   n_frame_req  in   frames per run (0 = free-run until stop)
//   msg_full     in   FIFO almost-full
//   msg_valid    out  FIFO write enable
//   msg          out  message word
//   busy         out  high from accepted start until back in IDLE
//   frame_done   out  pulse with the last pixel word of each frame
//   n_frame      out  frames completed in the current run
//
// Optional feature macro: CAMERA_GEN_LFSR_EN
//   defined   -> DN on LVAL words comes from a 12-bit Fibonacci LFSR
//                (x^12+x^11+x^10+x^4+1), seeded to 12'hACE on start and
//                advanced only on issued LVAL words.
//   undefined -> DN is the ramp (n_frame + row + col) mod 4096.
// ---------------------------------------------------------------------------
module camera_msg_gen #(
  parameter int XB_SIZE      = 32,
  parameter int N_COL        = 2048,
  parameter int N_ROW        = 2064,
  parameter int N_INTERLINE  = 8,
  parameter int N_INTERFRAME = 16,
  parameter int N_FRAME_SIZE = 20
) (
  input  logic                    bus_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [N_FRAME_SIZE-1:0] n_frame_req,
  input  logic                    msg_full,
  output logic                    msg_valid,
  output logic [XB_SIZE-1:0]      msg,
  output logic                    busy,
  output logic                    frame_done,
  output logic [N_FRAME_SIZE-1:0] n_frame
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTERFRAME,
    ST_INTRALINE,
    ST_INTERLINE,
    ST_TRAIL
  } state_t;

  localparam int GAP_MAX = (N_INTERFRAME > N_INTERLINE) ? N_INTERFRAME : N_INTERLINE;
  localparam int CW      = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

  localparam logic [CW-1:0] IF_LAST  = CW'(N_INTERFRAME - 1);
  localparam logic [CW-1:0] IL_LAST  = CW'(N_INTERLINE - 1);
  localparam logic [11:0]   COL_LAST = 12'(N_COL - 1);
  localparam logic [11:0]   ROW_LAST = 12'(N_ROW - 1);

  // Registered state
  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [11:0]             r_row;
  logic [11:0]             r_col;
  logic [N_FRAME_SIZE-1:0] r_nframe;
  logic [N_FRAME_SIZE-1:0] r_req;
  logic                    r_msg_valid;
  logic [XB_SIZE-1:0]      r_msg;
  logic                    r_frame_done;

  // Effective current values: an accepted start is folded in here so that the
  // first INTERFRAME word can be issued on the very edge that accepts start.
  state_t                  w_state;
  logic [CW-1:0]           w_cnt;
  logic [11:0]             w_row;
  logic [11:0]             w_col;
  logic [N_FRAME_SIZE-1:0] w_nframe;
  logic [N_FRAME_SIZE-1:0] w_req;
  logic [N_FRAME_SIZE-1:0] w_nframe_inc;
  logic                    w_issue;

  // Next values
  state_t                  w_state_next;
  logic [CW-1:0]           w_cnt_next;
  logic [11:0]             w_row_next;
  logic [11:0]             w_col_next;
  logic [N_FRAME_SIZE-1:0] w_nframe_next;
  logic                    w_valid_next;
  logic [XB_SIZE-1:0]      w_msg_next;
  logic                    w_frame_done_next;

  logic                    w_fval;
  logic                    w_lval;
  logic [11:0]             w_dn;

`ifdef CAMERA_GEN_LFSR_EN
  logic [11:0] r_lfsr;
  logic [11:0] w_lfsr;
  logic [11:0] w_lfsr_next;
`endif

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_row    = r_row;
    w_col    = r_col;
    w_nframe = r_nframe;
    w_req    = r_req;
`ifdef CAMERA_GEN_LFSR_EN
    w_lfsr   = r_lfsr;
`endif
    if (r_state == ST_IDLE && start) begin
      w_state  = ST_INTERFRAME;
      w_cnt    = '0;
      w_row    = '0;
      w_col    = '0;
      w_nframe = '0;
      w_req    = n_frame_req;
`ifdef CAMERA_GEN_LFSR_EN
      w_lfsr   = 12'hACE;
`endif
    end
  end

  assign w_issue      = (w_state != ST_IDLE) && !msg_full;
  assign w_nframe_inc = w_nframe + N_FRAME_SIZE'(1);

  always_comb begin
    w_state_next      = w_state;
    w_cnt_next        = w_cnt;
    w_row_next        = w_row;
    w_col_next        = w_col;
    w_nframe_next     = w_nframe;
    w_valid_next      = 1'b0;
    w_msg_next        = r_msg;
    w_frame_done_next = 1'b0;
    w_fval            = 1'b0;
    w_lval            = 1'b0;
    w_dn              = '0;
`ifdef CAMERA_GEN_LFSR_EN
    w_lfsr_next       = w_lfsr;
`endif

    if (w_issue) begin
      w_valid_next = 1'b1;
      case (w_state)
        ST_INTERFRAME: begin
          if (w_cnt == IF_LAST) begin
            w_cnt_next   = '0;
            w_row_next   = '0;
            w_col_next   = '0;
            w_state_next = ST_INTRALINE;
          end else begin
            w_cnt_next = w_cnt + CW'(1);
          end
        end
        ST_INTRALINE: begin
          w_fval = 1'b1;
          w_lval = 1'b1;
`ifdef CAMERA_GEN_LFSR_EN
          w_dn        = w_lfsr;
          w_lfsr_next = {w_lfsr[10:0], w_lfsr[11] ^ w_lfsr[10] ^ w_lfsr[9] ^ w_lfsr[3]};
`else
          w_dn = 12'(w_nframe) + w_row + w_col;
`endif
          if (w_col == COL_LAST) begin
            w_col_next = '0;
            if (w_row != ROW_LAST) begin
              w_row_next   = w_row + 12'd1;
              w_cnt_next   = '0;
              w_state_next = ST_INTERLINE;
            end else begin
              w_frame_done_next = 1'b1;
              w_nframe_next     = w_nframe_inc;
              w_cnt_next        = '0;
              // A zero request means free-run; only stop can end it.
              if (((w_req != '0) && (w_nframe_inc == w_req)) || stop)
                w_state_next = ST_TRAIL;
              else
                w_state_next = ST_INTERFRAME;
            end
          end else begin
            w_col_next = w_col + 12'd1;
          end
        end
        ST_INTERLINE: begin
          w_fval = 1'b1;
          if (w_cnt == IL_LAST) begin
            w_cnt_next   = '0;
            w_col_next   = '0;
            w_state_next = ST_INTRALINE;
          end else begin
            w_cnt_next = w_cnt + CW'(1);
          end
        end
        ST_TRAIL: begin
          if (w_cnt == IF_LAST) begin
            w_cnt_next   = '0;
            w_state_next = ST_IDLE;
          end else begin
            w_cnt_next = w_cnt + CW'(1);
          end
        end
        default: begin
          w_valid_next = 1'b0;
        end
      endcase

      w_msg_next       = '0;
      w_msg_next[4]    = w_lval;
      w_msg_next[5]    = w_fval;
      w_msg_next[19:8] = w_dn;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_nframe     <= '0;
      r_req        <= '0;
      r_msg_valid  <= 1'b0;
      r_msg        <= '0;
      r_frame_done <= 1'b0;
`ifdef CAMERA_GEN_LFSR_EN
      r_lfsr       <= 12'hACE;
`endif
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_row        <= w_row_next;
      r_col        <= w_col_next;
      r_nframe     <= w_nframe_next;
      r_req        <= w_req;
      r_msg_valid  <= w_valid_next;
      r_msg        <= w_msg_next;
      r_frame_done <= w_frame_done_next;
`ifdef CAMERA_GEN_LFSR_EN
      r_lfsr       <= w_lfsr_next;
`endif
    end
  end

  assign msg_valid  = r_msg_valid;
  assign msg        = r_msg;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign n_frame    = r_nframe;

endmodule

// File: doc/camera_msg_gen.md
# camera_msg_gen

Camera-side transmitter for the PC→FPGA pixel message stream. Generates frame-timed pixel messages (FVAL/LVAL flags plus 12-bit DN) in exactly the word format the frame processor's pixel path decodes, and writes them into the bus-side message FIFO under full-flag flow control. Used as an on-chip camera emulator for bring-up and regression in place of the host pixel feed.

## Interface
Parameters:
- XB_SIZE, 32: message word width; must be >= 24.
- N_COL, 2048: pixels per line (LVAL high words per row); 1..4095.
- N_ROW, 2064: lines per frame; 1..4095.
- N_INTERLINE, 8: words with FVAL=1, LVAL=0 between rows; >= 1.
- N_INTERFRAME, 16: words with FVAL=0 before each frame and after the last; >= 1.
- N_FRAME_SIZE, 20: frame counter width.

Ports:
- bus_clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- stop  in  1  level; when sampled high, run ends after the current frame.
- n_frame_req  in  N_FRAME_SIZE  frames per run, sampled on start; 0 = free-run until stop.
- msg_full  in  1  FIFO almost-full.
- msg_valid  out  1  write enable; one word is written per cycle it is high.
- msg  out  XB_SIZE  message word.
- busy  out  1  high from accepted start until return to IDLE.
- frame_done  out  1  one-cycle pulse with the last pixel word of each frame.
- n_frame  out  N_FRAME_SIZE  frames completed in the current run.

## Operation
- Word format: bit0=0 (pixel message), bit1=0, bit4=LVAL, bit5=FVAL, bits[19:8]=DN, all other bits 0 (including bits[23:20]).
- DN: (n_frame + row + col) mod 4096 on LVAL words; 0 on non-LVAL words.
- States: IDLE, INTERFRAME, INTRALINE, INTERLINE, TRAIL.
- IDLE: msg_valid=0. On start: latch n_frame_req, clear n_frame/row/col, busy=1, go to INTERFRAME.
- INTERFRAME: emit N_INTERFRAME words FVAL=0, LVAL=0, then row=0, col=0, go to INTRALINE.
- INTRALINE: emit N_COL words FVAL=1, LVAL=1, col incrementing. After the last column:
  - if row < N_ROW-1: row+1, go to INTERLINE;
  - else: pulse frame_done, n_frame+1. If the run is complete (n_frame+1 == latched request, request nonzero) or stop is high, go to TRAIL; otherwise go to INTERFRAME.
- INTERLINE: emit N_INTERLINE words FVAL=1, LVAL=0, then col=0, go to INTRALINE.
- TRAIL: emit N_INTERFRAME words FVAL=0, LVAL=0, then go to IDLE with busy=0.
- Words per frame: N_INTERFRAME + N_ROW*N_COL + (N_ROW-1)*N_INTERLINE; a run adds one trailing N_INTERFRAME block.
- n_frame wraps modulo 2^N_FRAME_SIZE in free-run.

## Timing
- Reset values: msg_valid=0, msg=0, busy=0, frame_done=0, n_frame=0, state IDLE. Reset mid-run aborts immediately; the partial frame is not completed.
- Registered outputs. A word is issued at cycle t+1 only if msg_full=0 at cycle t; this requires an almost-full margin of at least 1.
- Stall: while msg_full=1, msg_valid=0 and state, counters and DN hold. No word is dropped or duplicated across a stall.
- start to first word: 1 cycle when msg_full=0.
- Sustained rate: 1 word per cycle while not full. No bubbles between states.
- stop is sampled only at the last pixel word of a frame. A start arriving together with reset_n low is ignored.
- frame_done is coincident with the msg_valid of that frame's last LVAL word. n_frame updates on the same edge.

## Configuration
- CAMERA_GEN_LFSR_EN defined: DN on LVAL words is taken from a 12-bit Fibonacci LFSR (x^12+x^11+x^10+x^4+1). The LFSR is seeded to 12'hACE on start and advances only on issued LVAL words.
- Undefined: DN is the ramp defined above.

## Test plan
- Small single frame, ramp: N_COL=4, N_ROW=2, N_INTERLINE=2, N_INTERFRAME=3, n_frame_req=1, msg_full=0 -> 16 words, in order:
  - 3 words with {FVAL,LVAL}=00;
  - DN 0,1,2,3 (flags 11);
  - 2 words flags 10;
  - DN 1,2,3,4 (flags 11);
  - 3 words flags 00.
  - frame_done pulses once with DN 4; busy falls after the last word; n_frame=1.
- Same params, n_frame_req=2 -> 29 words total; second frame DN starts at 1; two frame_done pulses.
- Random msg_full toggling (50%) over a 2-frame run -> word sequence identical to the unstalled run; msg_valid never high in the cycle after msg_full=1.
- Free-run (n_frame_req=0), raise stop mid-frame 3 -> frame 3 completes, then 3 trailing FVAL=0 words, then IDLE; n_frame=3.
- Reset_n low mid-line, then start again -> outputs at reset values, new run begins with an INTERFRAME block and DN 0.
- With CAMERA_GEN_LFSR_EN: first LVAL DN=12'hACE, next DN equals one LFSR step; non-LVAL words have DN=0.
